// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the digit-by-digit square root.
// SQRT_ROUND_EN adds the round-to-nearest state.
package sqrt_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StCalc  = 2'd1,
`ifdef SQRT_ROUND_EN
      StRound = 2'd2,
`endif
      StDone  = 2'd3
   } state_e;

   function automatic int unsigned calc_n(input int unsigned width);
      return width / 2;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width / 2 + 1);
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring iteration: bring down two radicand bits, trial-subtract {R, 01}.
module sqrt_step #(
   parameter int unsigned N = 8
) (
   input  logic [N:0]   q_i,
   input  logic [N-1:0] r_i,
   input  logic [1:0]   bits_i,
   output logic [N:0]   q_o,
   output logic [N-1:0] r_o
);

   logic [N+2:0] q_shift;
   logic [N+2:0] sub;
   logic [N+2:0] diff;
   logic         ge;
   logic         unused_bits;

   // One bit of headroom so the compare is exact; the result fits back in N+1 bits.
   assign q_shift     = {q_i, bits_i};
   assign sub         = {1'b0, r_i, 2'b01};
   assign ge          = q_shift >= sub;
   assign diff        = q_shift - sub;
   assign unused_bits = ^{diff[N+2:N+1], r_i[N-1]};

   always_comb begin
      if (ge) begin
         q_o = diff[N:0];
         r_o = {r_i[N-2:0], 1'b1};
      end else begin
         q_o = q_shift[N:0];
         r_o = {r_i[N-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/sqrt_param.sv
// Multi-cycle integer square root, one root bit per clock, init/done handshake.
// SQRT_ROUND_EN enables a one-cycle round-to-nearest stage after the iterations.
module sqrt_param
   import sqrt_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init,
   input  logic [WIDTH-1:0]   A,
   output logic [WIDTH/2-1:0] result,
   output logic [WIDTH/2:0]   remainder,
   output logic               busy,
   output logic               done
);

   localparam int unsigned N  = calc_n(WIDTH);
   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     r_q, r_d;
   logic [N:0]       q_q, q_d;
   logic [N-1:0]     result_q, result_d;
   logic [N:0]       rem_q, rem_d;
   logic [N:0]       step_q;
   logic [N-1:0]     step_r;
   logic             start;
   logic             last_iter;

   assign start     = init && (state_q == StIdle || state_q == StDone);
   assign last_iter = (cnt_q == CW'(1));

   sqrt_step #(
      .N (N)
   ) u_step (
      .q_i    (q_q),
      .r_i    (r_q),
      .bits_i (shift_q[WIDTH-1 -: 2]),
      .q_o    (step_q),
      .r_o    (step_r)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (init) state_d = StCalc;
         StCalc: begin
            if (last_iter) begin
`ifdef SQRT_ROUND_EN
               state_d = StRound;
`else
               state_d = StDone;
`endif
            end
         end
`ifdef SQRT_ROUND_EN
         StRound: state_d = StDone;
`endif
         StDone:  state_d = init ? StCalc : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         StCalc:  busy = 1'b1;
`ifdef SQRT_ROUND_EN
         StRound: busy = 1'b1;
`endif
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      r_d      = r_q;
      q_d      = q_q;
      result_d = result_q;
      rem_d    = rem_q;
      if (start) begin
         shift_d = A;
         cnt_d   = CW'(N);
         r_d     = '0;
         q_d     = '0;
      end else if (state_q == StCalc) begin
         shift_d = shift_q << 2;
         cnt_d   = cnt_q - CW'(1);
         r_d     = step_r;
         q_d     = step_q;
`ifndef SQRT_ROUND_EN
         // Outputs change only on the final iteration, never exposing partials.
         if (last_iter) begin
            result_d = step_r;
            rem_d    = step_q;
         end
`endif
      end
`ifdef SQRT_ROUND_EN
      else if (state_q == StRound) begin
         // Q > R means A > R^2 + R, i.e. sqrt(A) > R + 0.5.
         if (q_q > {1'b0, r_q} && !(&r_q)) begin
            result_d = r_q + N'(1);
         end else begin
            result_d = r_q;
         end
         rem_d = q_q;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q  <= '0;
         cnt_q    <= '0;
         r_q      <= '0;
         q_q      <= '0;
         result_q <= '0;
         rem_q    <= '0;
      end else begin
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         r_q      <= r_d;
         q_q      <= q_d;
         result_q <= result_d;
         rem_q    <= rem_d;
      end
   end

   assign result    = result_q;
   assign remainder = rem_q;

endmodule

// File: tb/tb_sqrt_param.sv
// Self-checking bench for sqrt_param (WIDTH=16 and WIDTH=32 instances).
// Expectations follow SQRT_ROUND_EN when it is defined for the build.
module tb_sqrt_param;

`ifdef SQRT_ROUND_EN
   localparam int LAT16 = 9;
   localparam int LAT32 = 17;
`else
   localparam int LAT16 = 8;
   localparam int LAT32 = 16;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init16 = 1'b0;
   logic [15:0] a16 = '0;
   logic [7:0]  result16;
   logic [8:0]  rem16;
   logic        busy16, done16;
   logic        init32 = 1'b0;
   logic [31:0] a32 = '0;
   logic [15:0] result32;
   logic [16:0] rem32;
   logic        busy32, done32;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sqrt_param #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .init      (init16),
      .A         (a16),
      .result    (result16),
      .remainder (rem16),
      .busy      (busy16),
      .done      (done16)
   );

   sqrt_param #(.WIDTH(32)) dut32 (
      .clk       (clk),
      .rst       (rst),
      .init      (init32),
      .A         (a32),
      .result    (result32),
      .remainder (rem32),
      .busy      (busy32),
      .done      (done32)
   );

   typedef struct {
      logic [15:0] a;
      int          res_floor;
      int          res_round;
      int          rem;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: binary-search integer square root, optional round-to-nearest.
   function automatic void model(input longint a, input int n, output longint res,
                                 output longint rem);
      longint lo = 0;
      longint hi = (longint'(1) << n) - 1;
      longint mid;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= a) lo = mid;
         else hi = mid - 1;
      end
      rem = a - lo * lo;
      res = lo;
`ifdef SQRT_ROUND_EN
      if (rem > lo && lo != (longint'(1) << n) - 1) res = lo + 1;
`endif
   endfunction

   task automatic start16(input logic [15:0] a);
      @(negedge clk);
      init16 = 1'b1;
      a16    = a;
      @(negedge clk);
      init16 = 1'b0;
   endtask

   // Returns at the negedge where done is visible (or after the bound expires).
   task automatic wait_done16(output int edges);
      logic busy_bad = 1'b0;
      edges = 0;
      while (!done16 && edges < 40) begin
         if (busy16 !== 1'b1) busy_bad = 1'b1;
         @(negedge clk);
         edges++;
      end
      chk("busy_during_calc", busy_bad, 0);
   endtask

   task automatic run16(input string name, input logic [15:0] a, input longint er,
                        input longint em);
      int edges;
      start16(a);
      wait_done16(edges);
      chk({name, "_latency"}, edges, LAT16);
      chk({name, "_busy_at_done"}, busy16, 0);
      chk({name, "_result"}, result16, er);
      chk({name, "_remainder"}, rem16, em);
      @(negedge clk);
      chk({name, "_done_one_cycle"}, done16, 0);
   endtask

   task automatic run32(input string name, input logic [31:0] a);
      int     edges;
      longint er, em;
      model(a, 16, er, em);
      @(negedge clk);
      init32 = 1'b1;
      a32    = a;
      @(negedge clk);
      init32 = 1'b0;
      edges  = 0;
      while (!done32 && edges < 60) begin
         @(negedge clk);
         edges++;
      end
      chk({name, "_latency"}, edges, LAT32);
      chk({name, "_result"}, result32, er);
      chk({name, "_remainder"}, rem32, em);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int     edges;
      int     dones;
      longint er, em;
      logic [15:0] ra;

      vecs[0] = '{16'h0000, 0, 0, 0};
      vecs[1] = '{16'hFFFF, 255, 255, 510};
      vecs[2] = '{16'd144, 12, 12, 0};
      vecs[3] = '{16'd143, 11, 12, 22};
      vecs[4] = '{16'd156, 12, 12, 12};
      vecs[5] = '{16'd157, 12, 13, 13};
      vecs[6] = '{16'd1, 1, 1, 0};
      vecs[7] = '{16'd2, 1, 1, 1};
      vecs[8] = '{16'd3, 1, 2, 2};
      vecs[9] = '{16'd4, 2, 2, 0};

      repeat (3) @(negedge clk);
      chk("reset_result", result16, 0);
      chk("reset_remainder", rem16, 0);
      chk("reset_busy", busy16, 0);
      chk("reset_done", done16, 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
`ifdef SQRT_ROUND_EN
         run16($sformatf("vec%0d", i), vecs[i].a, vecs[i].res_round, vecs[i].rem);
`else
         run16($sformatf("vec%0d", i), vecs[i].a, vecs[i].res_floor, vecs[i].rem);
`endif
      end

      for (int i = 0; i < 25; i++) begin
         ra = 16'($urandom);
         model(ra, 8, er, em);
         run16($sformatf("rand%0d_a%0d", i, ra), ra, er, em);
      end

      // init while busy must be ignored.
      start16(16'd49);
      dones = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 2) begin
            init16 = 1'b1;
            a16    = 16'd100;
         end else begin
            init16 = 1'b0;
         end
         @(negedge clk);
         if (done16) dones++;
      end
      chk("ignore_init_done_count", dones, 1);
      chk("ignore_init_result", result16, 7);
      chk("ignore_init_remainder", rem16, 0);

      // Asynchronous reset mid-operation.
      start16(16'd1000);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_result", result16, 0);
      chk("abort_remainder", rem16, 0);
      chk("abort_busy", busy16, 0);
      chk("abort_done", done16, 0);
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done16) dones++;
      end
      chk("abort_no_done", dones, 0);
      run16("after_abort", 16'd4, 2, 0);

      // Restart straight from the done cycle.
      start16(16'd64);
      wait_done16(edges);
      chk("b2b_first_result", result16, 8);
      init16 = 1'b1;
      a16    = 16'd81;
      @(negedge clk);
      init16 = 1'b0;
      chk("b2b_busy_no_idle", busy16, 1);
      wait_done16(edges);
      chk("b2b_latency", edges, LAT16);
      chk("b2b_result", result16, 9);
      chk("b2b_remainder", rem16, 0);

      run32("w32_max", 32'hFFFF_FFFF);
      run32("w32_zero", 32'd0);
      for (int i = 0; i < 6; i++) begin
         run32($sformatf("w32_rand%0d", i), 32'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
